// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one bit-serial lane among NREQ word producers.
// Each granted word is sent LSB-first, framed by sof/eos, and followed by GAP idle cycles.
module serial_tx_arbiter #(
  parameter int BITS = 6,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] data,
  output logic [NREQ-1:0]      ack,
  output logic [IDW-1:0]       gnt_id,
  output logic                 busy,
  output logic                 sof,
  output logic                 q,
  output logic                 eos
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int GW = 4;
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d, cnt_inc;
  logic [GW-1:0]     gap_q, gap_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [BITS-1:0]   word_q, word_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              sof_q, sof_d;
  logic              q_q, q_d;
  logic              eos_q, eos_d;

  logic [IDW-1:0]    win_id;
  logic [BITS-1:0]   win_word;

  assign cnt_inc = count_q + CW'(1);

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    win_id   = '0;
    win_word = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(ptr_q) + i) % NREQ]) begin
        win_id   = IDW'((int'(ptr_q) + i) % NREQ);
        win_word = data[((int'(ptr_q) + i) % NREQ) * BITS +: BITS];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    sof_d   = 1'b0;
    q_d     = q_q;
    eos_d   = eos_q;

    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          q_d    = 1'b0;
          busy_d = 1'b0;
          eos_d  = 1'b0;
          if (|req) begin
            word_d  = win_word;
            ptr_d   = win_id;
            gnt_d   = win_id;
            ack_d   = NREQ'(1) << win_id;
            busy_d  = 1'b1;
            sof_d   = 1'b1;
            q_d     = win_word[0];
            count_d = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (count_q == LAST_BIT) begin
            count_d = '0;
            q_d     = 1'b0;
            eos_d   = 1'b0;
            gap_d   = '0;
            if (GAP > 0) begin
              state_d = ST_GAP;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            count_d = cnt_inc;
            q_d     = word_q[cnt_inc];
            eos_d   = (cnt_inc == LAST_BIT);
          end
        end
        ST_GAP: begin
          q_d    = 1'b0;
          eos_d  = 1'b0;
          busy_d = 1'b1;
          if (gap_q == LAST_GAP) begin
            gap_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gap_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      ack_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      sof_q   <= 1'b0;
      q_q     <= 1'b0;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      sof_q   <= sof_d;
      q_q     <= q_d;
      eos_q   <= eos_d;
    end
  end

  // NOTE: the word register is pure datapath, always loaded before use, so it has no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign ack    = ack_q;
  assign gnt_id = gnt_q;
  assign busy   = busy_q;
  assign sof    = sof_q;
  assign q      = q_q;
  assign eos    = eos_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: directed frame scenarios plus random traffic
// compared every cycle against a frame-phase reference model.
module tb_serial_tx_arbiter;

  localparam int BITS = 6;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int GAP  = 1;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] data;
  logic [NREQ-1:0]      ack;
  logic [IDW-1:0]       gnt_id;
  logic                 busy;
  logic                 sof;
  logic                 q;
  logic                 eos;

  serial_tx_arbiter #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .data(data),
    .ack(ack), .gnt_id(gnt_id), .busy(busy), .sof(sof), .q(q), .eos(eos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic cmp_on = 1'b0;

  // Reference model: phase 0 = idle, 1..BITS = bit (phase-1) on the lane, beyond = gap.
  int              m_p    = 0;
  int              m_ptr  = NREQ - 1;
  logic [BITS-1:0] m_word = '0;
  logic [NREQ-1:0] m_ack  = '0;
  logic [IDW-1:0]  m_gnt  = '0;
  logic            m_busy = 1'b0;
  logic            m_sof  = 1'b0;
  logic            m_q    = 1'b0;
  logic            m_eos  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic model_step();
    int w;
    if (!rst) begin
      m_p = 0; m_ptr = NREQ - 1;
      m_ack = '0; m_gnt = '0; m_busy = 1'b0; m_sof = 1'b0; m_q = 1'b0; m_eos = 1'b0;
    end else if (!en) begin
      m_ack = '0; m_sof = 1'b0;
    end else if (m_p == 0) begin
      m_ack = '0; m_sof = 1'b0; m_q = 1'b0; m_eos = 1'b0; m_busy = 1'b0;
      if (req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_word = data[w*BITS +: BITS];
        m_ptr  = w;
        m_gnt  = IDW'(w);
        m_ack  = NREQ'(1) << w;
        m_busy = 1'b1;
        m_sof  = 1'b1;
        m_p    = 1;
        m_q    = m_word[0];
        m_eos  = 1'b0;
      end
    end else begin
      m_p   = (m_p == BITS + GAP) ? 0 : m_p + 1;
      m_ack = '0;
      m_sof = 1'b0;
      if (m_p == 0) begin
        m_busy = 1'b0; m_q = 1'b0; m_eos = 1'b0;
      end else if (m_p <= BITS) begin
        m_busy = 1'b1; m_q = m_word[m_p-1]; m_eos = (m_p == BITS);
      end else begin
        m_busy = 1'b1; m_q = 1'b0; m_eos = 1'b0;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("cmp_ack",    32'(ack),    32'(m_ack));
        check("cmp_gnt_id", 32'(gnt_id), 32'(m_gnt));
        check("cmp_busy",   32'(busy),   32'(m_busy));
        check("cmp_sof",    32'(sof),    32'(m_sof));
        check("cmp_q",      32'(q),      32'(m_q));
        check("cmp_eos",    32'(eos),    32'(m_eos));
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input int budget, output int id, output int at);
    id = -1;
    at = -1;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
        at = cyc;
        return;
      end
    end
    n_chk++;
    $display("FAIL ack_timeout: got no ack in %0d cycles, expected one", budget);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, ack, gnt_id, busy, sof, q, eos}, 32'd0);
  endtask

  initial begin
    int id, at, prev_at;
    logic [BITS-1:0] w;

    rst = 1'b0; en = 1'b1; req = '0; data = '0;

    // Reset, then a single request from requester 0.
    tick();
    cmp_on = 1'b1;
    check_all_zero("reset_outputs_1");
    tick();
    check_all_zero("reset_outputs_2");
    rst = 1'b1;
    w = 6'b101101;
    data[0 +: BITS] = w;
    req = 4'b0001;
    tick();
    check("single_ack", 32'(ack), 32'h1);
    check("single_sof", 32'(sof), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_q0", 32'(q), 32'h1);
    check("model_q0", 32'(m_q), 32'h1);
    req = 4'b0000;
    for (int k = 1; k < BITS; k++) begin
      tick();
      check($sformatf("single_q%0d", k), 32'(q), 32'(w[k]));
      check($sformatf("single_eos%0d", k), 32'(eos), 32'(k == BITS - 1));
      check($sformatf("single_sof%0d", k), 32'(sof), 32'h0);
    end
    tick();
    check("gap_busy", 32'(busy), 32'h1);
    check("gap_q", 32'(q), 32'h0);
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Round-robin from a fresh reset with all four requesters waiting.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    prev_at = 0;
    for (int g = 0; g < NREQ; g++) begin
      wait_ack(20, id, at);
      check($sformatf("rr_grant%0d", g), 32'(id), 32'(g));
      check($sformatf("rr_gnt_id%0d", g), 32'(gnt_id), 32'(g));
      check($sformatf("rr_model_gnt%0d", g), 32'(m_gnt), 32'(g));
      if (g > 0) check($sformatf("rr_spacing%0d", g), 32'(at - prev_at), 32'd8);
      prev_at = at;
      if (id >= 0) req[id] = 1'b0;
    end

    // Last grant 2, then 0 and 2 contend: 0 must go first.
    req = 4'b0100;
    wait_ack(20, id, at);
    check("hist_grant2", 32'(id), 32'd2);
    req = 4'b0101;
    wait_ack(20, id, at);
    check("contend_first", 32'(id), 32'd0);
    req = 4'b0100;
    wait_ack(20, id, at);
    check("contend_second", 32'(id), 32'd2);
    req = 4'b0000;

    // Data changes mid-frame; lane keeps the captured word.
    w = 6'b110010;
    data[0 +: BITS] = w;
    req = 4'b0001;
    wait_ack(20, id, at);
    check("capture_grant", 32'(id), 32'd0);
    check("capture_q0", 32'(q), 32'(w[0]));
    req = 4'b0000;
    for (int k = 1; k < BITS; k++) begin
      tick();
      check($sformatf("capture_q%0d", k), 32'(q), 32'(w[k]));
      check($sformatf("capture_eos%0d", k), 32'(eos), 32'(k == BITS - 1));
      if (k == 1) data[0 +: BITS] = '0;
    end

    // en stall for 3 cycles while bit 3 is on the lane.
    w = 6'b101000;
    data[0 +: BITS] = w;
    req = 4'b0001;
    wait_ack(20, id, at);
    req = 4'b0000;
    tick(); tick(); tick();
    check("stall_bit3", 32'(q), 32'(w[3]));
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall_q%0d", s), 32'(q), 32'(w[3]));
      check($sformatf("stall_pulses%0d", s), {28'd0, ack[1:0], sof, eos}, 32'd0);
      check($sformatf("stall_busy%0d", s), 32'(busy), 32'h1);
    end
    en = 1'b1;
    tick();
    check("resume_q4", 32'(q), 32'(w[4]));
    check("resume_eos4", 32'(eos), 32'h0);
    check("resume_sof", 32'(sof), 32'h0);
    tick();
    check("resume_q5", 32'(q), 32'(w[5]));
    check("resume_eos5", 32'(eos), 32'h1);

    // Reset at bit 2 of a frame granted to requester 0.
    data[0 +: BITS] = 6'b111111;
    req = 4'b0001;
    wait_ack(20, id, at);
    check("pre_reset_grant", 32'(id), 32'd0);
    req = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all_zero("midframe_reset");
    rst = 1'b1;
    req = 4'b0011;
    wait_ack(20, id, at);
    check("post_reset_grant", 32'(id), 32'd0);
    req[0] = 1'b0;
    wait_ack(20, id, at);
    check("post_reset_next", 32'(id), 32'd1);
    req = 4'b0000;

    // Random traffic checked by the compare process.
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst = ($urandom_range(0, 399) != 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 2) == 0) data[i*BITS +: BITS] = BITS'($urandom());
      end
    end
    rst = 1'b1; en = 1'b1; req = '0;
    for (int n = 0; n < 20; n++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Round-robin scheduler that shares one bit-serial output lane among NREQ requesters. It grants one requester at a time, captures that requester's BITS-wide word, and sequences it out LSB-first, one bit per clock. It marks frame start (sof) and end (eos) and inserts an optional idle gap between frames. It sits between parallel word producers and the single serial output pin.

Parameters:
BITS, 6, word width in bits; also the number of serial bits per frame (BITS >= 2).
NREQ, 4, number of requesters (2..2**IDW).
IDW, 2, width of gnt_id.
GAP, 1, idle cycles inserted after each frame's last bit (0..15).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge).
en  input  1  advance enable; 0 freezes all state and outputs.
req  input  NREQ  per-requester request level.
data  input  NREQ*BITS  requester i word on data[i*BITS +: BITS].
ack  output  NREQ  one-hot pulse, 1 cycle, when requester i's word is captured.
gnt_id  output  IDW  index of the requester currently owning the lane.
busy  output  1  high from capture through the end of the gap.
sof  output  1  high with bit 0 of a frame.
q  output  1  serial data, LSB first.
eos  output  1  high with bit BITS-1 of a frame.

Behaviour:
- Only one clock, clk. All outputs are registered.
- Reset (rst==0 at the edge):
  - state=IDLE, count=0, ptr=NREQ-1.
  - ack=0, gnt_id=0, busy=0, sof=0, q=0, eos=0.
  - Reset overrides en. A frame in flight is dropped with no eos.
- States: IDLE, SHIFT, GAP.
- IDLE, with en=1 and |req in cycle c:
  - Winner = first asserted req scanning ptr+1, ptr+2, ... mod NREQ.
  - At the end of cycle c, the winner's word is latched and ptr=winner.
  - In cycle c+1: gnt_id=winner, ack[winner]=1, busy=1, sof=1, q=word[0], state=SHIFT, count=0.
- IDLE with no req: q=0, busy=0, ack=0. State and ptr are unchanged.
- SHIFT:
  - In cycle c+1+k, q=word[k] for k=0..BITS-1.
  - ack and sof are high only in cycle c+1.
  - eos=1 only in cycle c+BITS, together with word[BITS-1].
  - After the last bit: go to GAP if GAP>0, else IDLE.
- GAP: q=0, busy=1, gnt_id held, lasts GAP cycles, then IDLE.
- Frame period for back-to-back requests is BITS+GAP+1 cycles. The one IDLE cycle is the arbitration cycle.
- Word capture:
  - The latched word is immune to later changes on data.
  - Requesters must drop req after seeing ack.
  - req is only sampled in IDLE. req asserted during SHIFT or GAP waits; it is not lost if still held at IDLE.
- Fairness: the last-granted requester has the lowest priority next round. After reset, requester 0 has the highest priority.
- en=0:
  - state, count, ptr and the latched word hold; q, gnt_id, busy and eos hold their values.
  - ack and sof are forced to 0, so a pulse is never duplicated.
  - When en returns to 1, the sequence resumes where it stopped; sof and ack are not re-issued.
  - en=0 in IDLE blocks arbitration.
- count wraps to 0 at the end of each frame. It never exceeds BITS-1.
- req bits at indices >= NREQ do not exist. Unused gnt_id codes never appear.

Test Plan:
- Reset then single request: rst=0 for 2 cycles, all outputs 0; then BITS=6, req=4'b0001, data0=6'b101101. Required: ack[0] and sof in cycle c+1; q=1,0,1,1,0,1 on cycles c+1..c+6; eos only on c+6; busy low again at c+8 (GAP=1).
- Round-robin: req=4'b1111 held, each requester dropping its req one cycle after its ack. Required: grant order 0,1,2,3; gnt_id follows; ack pulses 8 cycles apart.
- Contention after history: last grant=2, then req=4'b0101. Required: requester 0 is granted before requester 2 re-wins.
- Data change mid-frame: data0 changes to 6'b000000 during SHIFT. Required: the remaining q bits match the originally captured word.
- en stall: en=0 for 3 cycles at bit 3. Required: q holds word[3] and sof/ack stay 0. After en=1, bits 4..5 follow, and eos moves out by 3 cycles.
- Reset mid-frame: rst=0 at bit 2. Required: all outputs 0 the next cycle, no eos for that frame. The next arbitration grants requester 0 first.
